lfsr_step_controller: RTL and testbench

- Sequencing controller for the 4-bit LFSR on the 16 MHz board.
- Replaces the free-running divided clock with a single-clock step enable, driven by a programmable divider.
- Provides run/pause, single-step and debounced load from the board buttons.
- Monitors the LFSR output and forces a reseed when the register locks up.
- Sits between the raw board inputs and the LFSR's enable/load/data pins; the LFSR runs on clk and advances only when step_en is high.

---
 rtl/lfsr_step_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_lfsr_step_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_step_controller.sv
// Step/load sequencer for the 4-bit board LFSR.
// Turns raw buttons into debounced events, paces RUN mode with a programmable
// divider and reseeds the LFSR when its output stops changing.
module lfsr_step_controller #(
  parameter int unsigned          DivWidth   = 24,
  parameter logic [DivWidth-1:0]  DivDefault = DivWidth'(24'h0FFFFF),
  parameter int unsigned          DebWidth   = 16,
  parameter int unsigned          DebCycles  = 40000,
  parameter int unsigned          LockSteps  = 2,
  parameter logic [3:0]           Seed       = 4'h1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_run_i,
  input  logic       btn_step_i,
  input  logic       btn_load_i,
  input  logic [3:0] data_i,
  input  logic [1:0] div_sel_i,
  input  logic [3:0] lfsr_q_i,
  output logic       step_en_o,
  output logic       load_en_o,
  output logic [3:0] load_data_o,
  output logic       running_o,
  output logic       lockup_o
);

  localparam int unsigned           StallWidth = $clog2(LockSteps + 1);
  localparam logic [DebWidth-1:0]   DebLast    = DebWidth'(DebCycles - 1);
  localparam logic [StallWidth-1:0] StallLimit = StallWidth'(LockSteps);

  typedef enum logic [1:0] {StPause, StRun, StLoad, StRecover} state_e;

  // ---------------------------------------------------------------------------
  // Button synchronizers and debouncers; bit 0 = run, 1 = step, 2 = load
  // ---------------------------------------------------------------------------
  logic [2:0]          btn_raw;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          acc_q, acc_d;
  logic [2:0]          acc_dly_q;
  logic [DebWidth-1:0] deb_cnt_q [3];
  logic [DebWidth-1:0] deb_cnt_d [3];
  logic [2:0]          ev;
  logic                ev_run, ev_step, ev_load;

  assign btn_raw = {btn_load_i, btn_step_i, btn_run_i};

  // Count how long the synchronized level has disagreed with the accepted one.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      acc_d[i]     = acc_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          acc_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebWidth'(1);
        end
      end
    end
  end

  // Synchronizer, debounce counter and accepted-level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      acc_dly_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // One-cycle event on each accepted 0->1 change.
  assign ev      = acc_q & ~acc_dly_q;
  assign ev_run  = ev[0];
  assign ev_step = ev[1];
  assign ev_load = ev[2];

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  state_e                ret_q, ret_d;
  logic [DivWidth-1:0]   div_cnt_q, div_cnt_d;
  logic [DivWidth-1:0]   tc;
  logic                  tick;
  logic [3:0]            load_data_q, load_data_d;
  logic                  running_q, running_d;
  logic                  lockup_q, lockup_d;
  logic [StallWidth-1:0] stall_q, stall_d;
  logic [3:0]            prev_q, prev_d;
  logic                  valid_q, valid_d;
  logic                  step_en;

  // ---------------------------------------------------------------------------
  // Step divider
  // ---------------------------------------------------------------------------
  assign tc = DivDefault >> {div_sel_i, 1'b0};

  // Count in RUN; a one-cycle LOAD/RECOVER detour from RUN freezes the count so
  // the step cadence picks up where it left off.
  always_comb begin
    tick      = 1'b0;
    div_cnt_d = '0;
    case (state_q)
      StRun: begin
        if (div_cnt_q >= tc) begin
          tick = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DivWidth'(1);
        end
      end
      StLoad, StRecover: begin
        if (ret_q == StRun) begin
          div_cnt_d = div_cnt_q;
        end
      end
      default: div_cnt_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM with lockup detection
  // ---------------------------------------------------------------------------
  // Next-state logic: event priority load > run > step, lockup overrides all.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    load_data_d = load_data_q;
    lockup_d    = lockup_q;
    stall_d     = stall_q;
    prev_d      = prev_q;
    valid_d     = valid_q;
    step_en     = 1'b0;

    case (state_q)
      StPause: begin
        if (ev_load) begin
          state_d     = StLoad;
          ret_d       = StPause;
          load_data_d = data_i;
        end else if (ev_run) begin
          state_d = StRun;
        end else if (ev_step) begin
          step_en = 1'b1;
        end
      end
      StRun: begin
        step_en = tick;
        if (ev_load) begin
          state_d     = StLoad;
          ret_d       = StRun;
          load_data_d = data_i;
        end else if (ev_run) begin
          state_d = StPause;
        end
      end
      StLoad, StRecover: begin
        state_d = ret_q;
        stall_d = '0;
        valid_d = 1'b0;
      end
      default: state_d = StPause;
    endcase

    // Compare each stepped value with the previous one; a stuck register is
    // reseeded, and that takes precedence over any same-cycle load.
    if (step_en) begin
      if (valid_q && (lfsr_q_i == prev_q)) begin
        stall_d = stall_q + StallWidth'(1);
      end else begin
        stall_d = '0;
      end
      prev_d  = lfsr_q_i;
      valid_d = 1'b1;
      if (stall_d >= StallLimit) begin
        state_d     = StRecover;
        ret_d       = state_q;
        load_data_d = Seed;
        lockup_d    = 1'b1;
      end
    end
  end

  // running tracks the state register, including a detour that returns to RUN.
  always_comb begin
    running_d = (state_q == StRun) ||
                (((state_q == StLoad) || (state_q == StRecover)) && (ret_q == StRun));
  end

  // FSM, divider, lockup tracker and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StPause;
      ret_q       <= StPause;
      div_cnt_q   <= '0;
      load_data_q <= '0;
      running_q   <= 1'b0;
      lockup_q    <= 1'b0;
      stall_q     <= '0;
      prev_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      div_cnt_q   <= div_cnt_d;
      load_data_q <= load_data_d;
      running_q   <= running_d;
      lockup_q    <= lockup_d;
      stall_q     <= stall_d;
      prev_q      <= prev_d;
      valid_q     <= valid_d;
    end
  end

  assign step_en_o   = step_en;
  assign load_en_o   = (state_q == StLoad) || (state_q == StRecover);
  assign load_data_o = load_data_q;
  assign running_o   = running_q;
  assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_lfsr_step_controller.sv
// Directed bench for lfsr_step_controller with short debounce and divider.
module tb_lfsr_step_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_load = 1'b0;
  logic [3:0] data = 4'h0;
  logic [1:0] div_sel = 2'd0;
  logic [3:0] lfsr = 4'h5;
  logic       lfsr_force = 1'b0;
  logic       step_en;
  logic       load_en;
  logic [3:0] load_data;
  logic       running;
  logic       lockup;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_step_controller #(
    .DivWidth  (24),
    .DivDefault(24'd15),
    .DebWidth  (16),
    .DebCycles (4),
    .LockSteps (2),
    .Seed      (4'h1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .btn_run_i  (btn_run),
    .btn_step_i (btn_step),
    .btn_load_i (btn_load),
    .data_i     (data),
    .div_sel_i  (div_sel),
    .lfsr_q_i   (lfsr),
    .step_en_o  (step_en),
    .load_en_o  (load_en),
    .load_data_o(load_data),
    .running_o  (running),
    .lockup_o   (lockup)
  );

  // Stand-in LFSR: counts on steps (never repeats), takes loads, or sticks at 0.
  always @(posedge clk) begin
    if (lfsr_force) lfsr <= 4'h0;
    else if (load_en) lfsr <= load_data;
    else if (step_en) lfsr <= lfsr + 4'h1;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (step_en !== 1'b0) begin n_fail++; $display("FAIL reset_step_en got %b want 0", step_en); end
    n_tests++; if (load_en !== 1'b0) begin n_fail++; $display("FAIL reset_load_en got %b want 0", load_en); end
    n_tests++; if (load_data !== 4'h0) begin n_fail++; $display("FAIL reset_load_data got %h want 0", load_data); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
    n_tests++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL reset_lockup got %b want 0", lockup); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_debounce();
    int steps;
    int first;
    steps = 0;
    btn_step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (step_en) steps++;
      if (i == 3) btn_step = 1'b0;
    end
    n_tests++; if (steps != 0) begin n_fail++; $display("FAIL debounce_glitch steps got %0d want 0", steps); end
    steps = 0;
    first = -1;
    btn_step = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (step_en) begin
        steps++;
        if (first < 0) first = i;
      end
      if (i == 10) btn_step = 1'b0;
    end
    n_tests++; if (first != 6) begin n_fail++; $display("FAIL debounce_latency got %0d want 6", first); end
    n_tests++; if (steps != 1) begin n_fail++; $display("FAIL debounce_pulses got %0d want 1", steps); end
  endtask

  task automatic test_run_rate();
    int exp_steps [8] = '{22, 38, 54, 58, 62, 66, 70, 74};
    int got [$];
    btn_run = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (step_en) got.push_back(i);
      if (i == 40) begin
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running got %b want 1", running); end
      end
      if (i == 90) begin
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL run_paused got %b want 0", running); end
      end
      if (i == 10) btn_run = 1'b0;
      if (i == 54) div_sel = 2'd1;
      if (i == 70) btn_run = 1'b1;
      if (i == 80) btn_run = 1'b0;
    end
    n_tests++;
    if (got.size() != 8) begin
      n_fail++; $display("FAIL run_step_count got %0d want 8", got.size());
    end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (k >= got.size() || got[k] != exp_steps[k]) begin
        n_fail++;
        $display("FAIL run_step_%0d got %0d want %0d", k, (k < got.size()) ? got[k] : -1,
                 exp_steps[k]);
      end
    end
  endtask

  task automatic test_load();
    int loads = 0;
    int load_at = -1;
    logic [3:0] load_val = 4'h0;
    int run_drop = 0;
    int next_step = -1;
    btn_run = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (load_en) begin
        loads++; load_at = i; load_val = load_data;
        n_tests++; if (step_en !== 1'b0) begin n_fail++; $display("FAIL load_step_overlap got %b want 0", step_en); end
      end
      if (i >= 10 && running !== 1'b1) run_drop++;
      if (i > 28 && step_en && next_step < 0) next_step = i;
      if (i == 29) begin
        n_tests++; if (load_data !== 4'hA) begin n_fail++; $display("FAIL load_data_hold got %h want a", load_data); end
      end
      if (i == 10) btn_run = 1'b0;
      if (i == 21) begin data = 4'hA; btn_load = 1'b1; end
      if (i == 28) data = 4'h5;
      if (i == 31) btn_load = 1'b0;
    end
    n_tests++; if (loads != 1) begin n_fail++; $display("FAIL load_count got %0d want 1", loads); end
    n_tests++; if (load_at != 28) begin n_fail++; $display("FAIL load_cycle got %0d want 28", load_at); end
    n_tests++; if (load_val !== 4'hA) begin n_fail++; $display("FAIL load_value got %h want a", load_val); end
    n_tests++; if (run_drop != 0) begin n_fail++; $display("FAIL load_running_drops got %0d want 0", run_drop); end
    n_tests++;
    if (next_step < 29 || next_step > 33) begin
      n_fail++; $display("FAIL load_resume_step got %0d want 29..33", next_step);
    end
  endtask

  task automatic test_priority();
    int loads = 0;
    int load_at = -1;
    logic [3:0] load_val = 4'h0;
    int run_drop = 0;
    int steps_after = 0;
    data = 4'h3;
    btn_load = 1'b1;
    btn_run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (load_en) begin loads++; load_at = i; load_val = load_data; end
      if (running !== 1'b1) run_drop++;
      if (i > 10 && step_en) steps_after++;
      if (i == 10) begin btn_load = 1'b0; btn_run = 1'b0; end
    end
    n_tests++; if (loads != 1) begin n_fail++; $display("FAIL prio_load_count got %0d want 1", loads); end
    n_tests++; if (load_at != 7) begin n_fail++; $display("FAIL prio_load_cycle got %0d want 7", load_at); end
    n_tests++; if (load_val !== 4'h3) begin n_fail++; $display("FAIL prio_load_value got %h want 3", load_val); end
    n_tests++; if (run_drop != 0) begin n_fail++; $display("FAIL prio_mode_changed got %0d want 0", run_drop); end
    n_tests++; if (steps_after == 0) begin n_fail++; $display("FAIL prio_stepping got %0d want >0", steps_after); end
  endtask

  task automatic test_no_lockup();
    int loads = 0;
    int lock_seen = 0;
    int steps = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (load_en) loads++;
      if (lockup !== 1'b0) lock_seen++;
      if (step_en) steps++;
    end
    n_tests++; if (loads != 0) begin n_fail++; $display("FAIL nolock_loads got %0d want 0", loads); end
    n_tests++; if (lock_seen != 0) begin n_fail++; $display("FAIL nolock_flag got %0d want 0", lock_seen); end
    n_tests++; if (steps < 15) begin n_fail++; $display("FAIL nolock_steps got %0d want >=15", steps); end
  endtask

  task automatic test_lockup();
    int first_load = -1;
    logic [3:0] first_val = 4'hF;
    int rec_at = -1;
    logic [3:0] rec_val = 4'h0;
    logic rec_lock = 1'b0;
    int steps_before = 0;
    int last_step = -1;
    data = 4'h0;
    btn_load = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (load_en && first_load < 0) begin
        first_load = i; first_val = load_data;
        n_tests++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL lock_early got %b want 0", lockup); end
      end else if (load_en && rec_at < 0) begin
        rec_at = i; rec_val = load_data; rec_lock = lockup;
        lfsr_force = 1'b0;
      end
      if (step_en && first_load > 0 && rec_at < 0) begin
        steps_before++; last_step = i;
      end
      if (i == 6) lfsr_force = 1'b1;
      if (i == 10) btn_load = 1'b0;
    end
    lfsr_force = 1'b0;
    n_tests++; if (first_load != 7) begin n_fail++; $display("FAIL lock_load_cycle got %0d want 7", first_load); end
    n_tests++; if (first_val !== 4'h0) begin n_fail++; $display("FAIL lock_load_value got %h want 0", first_val); end
    n_tests++; if (steps_before != 3) begin n_fail++; $display("FAIL lock_steps got %0d want 3", steps_before); end
    n_tests++;
    if (rec_at < 0 || rec_at != last_step + 1) begin
      n_fail++; $display("FAIL lock_recover_cycle got %0d want %0d", rec_at, last_step + 1);
    end
    n_tests++; if (rec_val !== 4'h1) begin n_fail++; $display("FAIL lock_seed got %h want 1", rec_val); end
    n_tests++; if (rec_lock !== 1'b1) begin n_fail++; $display("FAIL lock_flag got %b want 1", rec_lock); end
    n_tests++; if (lockup !== 1'b1) begin n_fail++; $display("FAIL lock_sticky got %b want 1", lockup); end
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL lock_running got %b want 1", running); end
  endtask

  task automatic test_reset_mid_run();
    bit found = 1'b0;
    int steps = 0;
    int runs = 0;
    int loads = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (step_en) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_pending_step got 0 want 1"); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (step_en !== 1'b0) begin n_fail++; $display("FAIL rst_async_step_en got %b want 0", step_en); end
    n_tests++; if (load_en !== 1'b0) begin n_fail++; $display("FAIL rst_async_load_en got %b want 0", load_en); end
    n_tests++; if (load_data !== 4'h0) begin n_fail++; $display("FAIL rst_async_load_data got %h want 0", load_data); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL rst_async_running got %b want 0", running); end
    n_tests++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL rst_async_lockup got %b want 0", lockup); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (step_en) steps++;
      if (running) runs++;
      if (load_en) loads++;
    end
    n_tests++; if (steps != 0) begin n_fail++; $display("FAIL rst_after_steps got %0d want 0", steps); end
    n_tests++; if (runs != 0) begin n_fail++; $display("FAIL rst_after_running got %0d want 0", runs); end
    n_tests++; if (loads != 0) begin n_fail++; $display("FAIL rst_after_loads got %0d want 0", loads); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_run_rate();
    test_load();
    test_priority();
    test_no_lockup();
    test_lockup();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
